// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Tracks in-flight destination registers and stalls decode on RAW/WAW.
// Revision : 1.0
// ============================================================================
module hazard_scoreboard #(
  parameter int MAX_LAT     = 4,
  parameter int CNT_W       = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_i,
  input  logic                   issue_valid_i,
  input  logic [4:0]             issue_rd_i,
  input  logic                   issue_wr_i,
  input  logic [4:0]             issue_rs1_i,
  input  logic [4:0]             issue_rs2_i,
  input  logic                   issue_use1_i,
  input  logic                   issue_use2_i,
  input  logic [CNT_W-1:0]       issue_lat_i,
  output logic                   stall_o,
  output logic                   issue_ok_o,
  output logic [31:0]            busy_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam logic [CNT_W-1:0] LAT_MAX = CNT_W'(MAX_LAT);
  localparam logic [CNT_W-1:0] LAT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt [32];
  logic [CNT_W-1:0] eff_lat;
  logic             raw1;
  logic             raw2;
  logic             waw;
  logic             update;

  always_comb begin
    eff_lat = issue_lat_i;
    if (issue_lat_i == '0)
      eff_lat = LAT_ONE;
    else if (issue_lat_i > LAT_MAX)
      eff_lat = LAT_MAX;
  end

  // cnt==1 completes this cycle and is forwardable next cycle, so only >1 stalls.
  assign raw1 = issue_valid_i & issue_use1_i & (issue_rs1_i != 5'd0) & (cnt[issue_rs1_i] > LAT_ONE);
  assign raw2 = issue_valid_i & issue_use2_i & (issue_rs2_i != 5'd0) & (cnt[issue_rs2_i] > LAT_ONE);
  assign waw  = issue_valid_i & issue_wr_i & (issue_rd_i != 5'd0) & (cnt[issue_rd_i] > eff_lat);

  assign stall_o    = raw1 | raw2 | waw;
  assign issue_ok_o = issue_valid_i & ~stall_o & ~reset_i;
  assign update     = issue_ok_o & issue_wr_i & (issue_rd_i != 5'd0);

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 32; i++)
        cnt[i] <= '0;
      stall_cnt_o <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (i == 0)
          cnt[i] <= '0;
        else if (update && (issue_rd_i == 5'(i)))
          cnt[i] <= eff_lat;
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - LAT_ONE;
      end
      if (stall_o && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

  genvar n;
  generate
    for (n = 0; n < 32; n++) begin : g_busy
      assign busy_o[n] = (cnt[n] != '0);
    end
  endgenerate

endmodule
`default_nettype wire
